// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared defaults and width helpers for the synchronous FIFO
//               family (single-clock, future async and multi-channel).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    localparam int unsigned c_DEF_DATA_WIDTH = 20;
    localparam int unsigned c_DEF_ADDR_WIDTH = 4;
    localparam int unsigned c_DEF_AF_LEVEL   = 12;
    localparam int unsigned c_DEF_AE_LEVEL   = 4;

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Occupancy needs one bit more than a pointer to represent a full FIFO.
    function automatic int unsigned cnt_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x DATA_WIDTH register array, synchronous write port.
//               Read port is registered, or combinational when
//               SYNC_FIFO_FWFT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned c_DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic w_unused;
    assign w_unused  = rst | rd_en_i;
    assign rd_data_o = mem_q[rd_addr_i];
`else
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Reads the head before a same-edge write can overwrite it (full + wr + rd).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised synchronous FIFO with exact count, thresholds
//               and sticky error flags. SYNC_FIFO_FWFT_EN selects FWFT output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = c_DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL   = c_DEF_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned c_CW        = cnt_width(ADDR_WIDTH);
    localparam int unsigned c_DEPTH     = depth_of(ADDR_WIDTH);
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_DEPTH[c_CW-1:0];
    localparam logic [c_CW-1:0] c_AF_CNT    = AF_LEVEL[c_CW-1:0];
    localparam logic [c_CW-1:0] c_AE_CNT    = AE_LEVEL[c_CW-1:0];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  w_empty, w_full;
    logic                  w_wr_ok, w_rd_ok;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_DEPTH_CNT);
    assign w_wr_ok = write & (~w_full | read);
    assign w_rd_ok = read & ~w_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (write & w_full & ~read);
        underflow_d = underflow_q | (read & w_empty);
        if (w_wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_wr_ok, w_rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk        (clk),
        .rst        (reset),
        .wr_en_i    (w_wr_ok),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (data_in),
        .rd_en_i    (w_rd_ok),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (w_rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Masking with empty keeps data_out at zero after reset until a word lands.
    assign valid    = ~w_empty;
    assign data_out = w_empty ? '0 : w_rd_data;
`else
    logic valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= w_rd_ok;
        end
    end

    assign valid    = valid_q;
    assign data_out = w_rd_data;
`endif

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (count_q <= c_AE_CNT);
    assign almost_full  = (count_q >= c_AF_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param against a queue model
//               (standard mode, or FWFT when SYNC_FIFO_FWFT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

    localparam int DW    = 20;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          valid, empty, full, almost_empty, almost_full;
    logic [AW:0]   count;
    logic          overflow, underflow;

    always #5 clk = ~clk;

    sync_fifo_param dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .write        (write),
        .read         (read),
        .data_out     (data_out),
        .valid        (valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_valid;
    logic [DW-1:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("valid", 32'(valid), 32'(n != 0));
        chk("data_out", 32'(data_out), (n != 0) ? 32'(q[0]) : 32'd0);
`else
        chk("valid", 32'(valid), 32'(m_valid));
        chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    // One clock: drive at negedge, update the model at posedge, sample 1 ns later.
    task automatic cycle(input bit rst, input bit w, input bit r, input logic [DW-1:0] d);
        int n;
        bit wok, rok;
        @(negedge clk);
        reset   = rst;
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clk);
        n = q.size();
        if (rst) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b0;
            m_dout  = '0;
        end else begin
            wok = w && (n < DEPTH || r);
            rok = r && (n > 0);
            if (w && n == DEPTH && !r) m_ovf = 1'b1;
            if (r && n == 0) m_unf = 1'b1;
            m_valid = rok;
            if (rok) m_dout = q.pop_front();
            if (wok) q.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        int wc, rc;
        bit w, r;

        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 20'h5a5a5);

        // Fill with 1..16, then one overflowing write.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
        cycle(1'b0, 1'b1, 1'b0, 20'h77777);

        // Drain in order, then one underflowing read.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Full FIFO, simultaneous write+read; the new word is the 16th read out.
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, DW'($urandom));
        cycle(1'b0, 1'b1, 1'b1, 20'habcde);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
`ifdef SYNC_FIFO_FWFT_EN
            if (i == DEPTH - 2) chk("abcde_head", 32'(data_out), 32'h000abcde);
`else
            if (i == DEPTH - 1) chk("abcde_out", 32'(data_out), 32'h000abcde);
`endif
        end

        // Empty FIFO, simultaneous write+read.
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 20'h12345);
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Random interleave of 40 writes and 40 reads, wrapping the pointers.
        wc = 0;
        rc = 0;
        for (int c = 0; c < 400 && (wc < 40 || rc < 40); c++) begin
            w = (wc < 40) && ($urandom_range(0, 1) == 1);
            r = (rc < 40) && (q.size() > 0) && ($urandom_range(0, 1) == 1);
            if (w && q.size() == DEPTH && !r) w = 1'b0;
            if (w) wc++;
            if (r) rc++;
            cycle(1'b0, w, r, DW'($urandom));
        end
        chk("interleave_done", 32'((wc == 40) && (rc == 40)), 32'd1);

        // Reset in the middle of a burst at count 9, with sticky errors set.
        cycle(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, DW'($urandom));
        chk("count_before_reset", 32'(count), 32'd9);
        cycle(1'b1, 1'b1, 1'b1, DW'($urandom));
        cycle(1'b0, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO: the next-generation replacement for the fixed 20x16 buffer. Configurable data width and power-of-two depth, full-depth occupancy (all DEPTH entries usable), exact occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Sits between producer and consumer blocks in the same clock domain; optional first-word-fall-through output mode.

## Interface
- DATA_WIDTH, 20, word width in bits
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries
- AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  DATA_WIDTH  write data
- write  in  1  write request
- read  in  1  read request (pop)
- data_out  out  DATA_WIDTH  read data
- valid  out  1  data_out holds a valid word
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_LEVEL
- almost_full  out  1  count >= AF_LEVEL
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full without read
- underflow  out  1  sticky: read attempted while empty

## Operation
- Write accepted (wr_ok) when write & (!full | read). Word stored at wr_ptr; wr_ptr increments, wraps DEPTH-1 -> 0.
- Read accepted (rd_ok) when read & !empty. rd_ptr increments, wraps DEPTH-1 -> 0.
- Empty FIFO with write & read: write accepted, read rejected, underflow set; count -> 1.
- Full FIFO with write & read: both accepted; count stays DEPTH.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Never leaves 0..DEPTH.
- empty, full, almost_empty, almost_full: combinational decode of registered count (no input-to-flag paths).
- overflow set on write & full & !read; underflow set on read & empty. Both hold until reset. Rejected operations change no pointer, count or memory.
- data_out never driven high-Z.

## Timing
- Reset (any cycle, including mid-burst): wr_ptr, rd_ptr, count = 0; empty = 1; almost_empty = 1; full, almost_full = 0 (AF_LEVEL >= 1); overflow, underflow, valid = 0; data_out = 0. Memory contents not cleared, never readable after reset.
- Flags and count reflect an operation in the cycle after the accepting edge.
- Write-to-read: word written at edge N is poppable from edge N+1.
- Standard mode: rd_ok at edge N -> data_out = word, valid = 1 after edge N, for one cycle. No rd_ok -> valid = 0, data_out holds last value.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through. data_out always shows the head word; valid = !empty; read acknowledges/pops the current word, next word (or valid = 0) visible after the edge. Zero read latency. Reset: valid = 0, data_out = 0 until first write lands.
- Undefined: standard registered read as in Timing (1-cycle latency, one-cycle valid pulse).
- Flags, count and error semantics identical in both modes.

## Structure
- Shared package sync_fifo_pkg: default DATA_WIDTH/ADDR_WIDTH/threshold constants and pointer/count width helpers, reused by future async and multi-channel FIFOs.
- One sub-module: sync_fifo_mem, DEPTH x DATA_WIDTH register array, synchronous write port, read port (registered in standard mode, combinational read of rd_ptr in FWFT).
- Top holds pointers, count, flag decode, error flags, output register.

## Test plan
- Reset, then 16 writes of 0x00001..0x00010 (defaults) -> count 16, full = 1 after 16th edge, almost_full from count 12; 17th write -> overflow = 1, count stays 16, contents unchanged.
- 16 reads after fill -> data_out 0x00001..0x00010 in order (1-cycle latency standard, zero in FWFT); empty = 1, almost_empty from count 4; extra read -> underflow = 1.
- Full FIFO, write & read same cycle with 0xABCDE -> count stays 16, no overflow, 0xABCDE emerges as 16th subsequent read.
- Empty FIFO, write & read same cycle -> count 1, underflow = 1, word readable next cycle.
- 40 interleaved writes/reads crossing pointer wrap twice -> output sequence equals input sequence, count matches reference model every cycle.
- Reset asserted with count = 9 mid-burst -> next cycle count 0, empty = 1, valid = 0, data_out = 0, overflow/underflow cleared.
